// File: rtl/uart_mem_sequencer.sv
// CPU-side master for the UART memory link: arbitrates imem/dmem reads, sends a 4-byte address, collects a 4-byte reply.
// Optional reply-timeout abort is enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_mem_sequencer #(
  parameter logic [31:0] TimeoutCycles = 32'd1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_ready_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,
  input  logic        dmem_valid_i,
  input  logic [31:0] dmem_addr_i,
  output logic        dmem_ready_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;
  typedef enum logic {G_IMEM, G_DMEM} grant_t;

  state_t      state;
  grant_t      grant;
  grant_t      last_grant;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic [31:0] addr;
  logic [31:0] word;
  logic        pick_d;
`ifdef UART_SEQ_TIMEOUT_EN
  logic [31:0] cnt;
`endif

  // A tie goes to the port that did not win last time.
  always_comb begin
    pick_d   = dmem_valid_i & (~imem_valid_i | (last_grant == G_IMEM));
    idx_next = idx + 2'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      grant         <= G_IMEM;
      last_grant    <= G_IMEM;
      idx           <= '0;
      addr          <= '0;
      word          <= '0;
      imem_ready_o  <= 1'b0;
      imem_rvalid_o <= 1'b0;
      imem_rdata_o  <= '0;
      dmem_ready_o  <= 1'b0;
      dmem_rvalid_o <= 1'b0;
      dmem_rdata_o  <= '0;
      tx_tdata_o    <= '0;
      tx_tvalid_o   <= 1'b0;
      rx_tready_o   <= 1'b0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
      cnt           <= '0;
`endif
    end else begin
      imem_ready_o  <= 1'b0;
      dmem_ready_o  <= 1'b0;
      imem_rvalid_o <= 1'b0;
      dmem_rvalid_o <= 1'b0;
      err_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (imem_valid_i | dmem_valid_i) begin
            if (pick_d) begin
              grant        <= G_DMEM;
              last_grant   <= G_DMEM;
              dmem_ready_o <= 1'b1;
              addr         <= dmem_addr_i;
              tx_tdata_o   <= dmem_addr_i[7:0];
            end else begin
              grant        <= G_IMEM;
              last_grant   <= G_IMEM;
              imem_ready_o <= 1'b1;
              addr         <= imem_addr_i;
              tx_tdata_o   <= imem_addr_i[7:0];
            end
            idx         <= '0;
            tx_tvalid_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (tx_tready_i) begin
            if (idx == 2'd3) begin
              idx         <= '0;
              tx_tvalid_o <= 1'b0;
              rx_tready_o <= 1'b1;
              state       <= RECV;
`ifdef UART_SEQ_TIMEOUT_EN
              cnt         <= '0;
`endif
            end else begin
              idx        <= idx_next;
              tx_tdata_o <= addr[8*idx_next +: 8];
            end
          end
        end
        RECV: begin
          if (rx_tvalid_i) begin
            word[8*idx +: 8] <= rx_tdata_i;
            idx              <= idx_next;
`ifdef UART_SEQ_TIMEOUT_EN
            cnt              <= '0;
`endif
            // Last byte bypasses the word register so the response is ready in RESP.
            if (idx == 2'd3) begin
              idx         <= '0;
              rx_tready_o <= 1'b0;
              state       <= RESP;
              if (grant == G_DMEM) begin
                dmem_rvalid_o <= 1'b1;
                dmem_rdata_o  <= {rx_tdata_i, word[23:0]};
              end else begin
                imem_rvalid_o <= 1'b1;
                imem_rdata_o  <= {rx_tdata_i, word[23:0]};
              end
            end
          end
`ifdef UART_SEQ_TIMEOUT_EN
          else if (cnt == TimeoutCycles - 32'd1) begin
            idx         <= '0;
            rx_tready_o <= 1'b0;
            err_o       <= 1'b1;
            state       <= RESP;
            if (grant == G_DMEM) begin
              dmem_rvalid_o <= 1'b1;
              dmem_rdata_o  <= 32'hDEADBEEF;
            end else begin
              imem_rvalid_o <= 1'b1;
              imem_rdata_o  <= 32'hDEADBEEF;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
`endif
        end
        RESP: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Directed, table-driven bench for uart_mem_sequencer; the timeout sequence runs when UART_SEQ_TIMEOUT_EN is defined.
module tb_uart_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        imem_ready_o, imem_rvalid_o;
  logic [31:0] imem_rdata_o;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic        dmem_ready_o, dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready = 1'b1;
  logic [7:0]  rx_tdata = '0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready_o, busy_o, err_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;

  always #5 clk = ~clk;

  uart_mem_sequencer #(.TimeoutCycles(32'd50)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .imem_valid_i(imem_valid), .imem_addr_i(imem_addr), .imem_ready_o(imem_ready_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid), .dmem_addr_i(dmem_addr), .dmem_ready_o(dmem_ready_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .tx_tdata_o(tx_tdata_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready),
    .rx_tdata_i(rx_tdata), .rx_tvalid_i(rx_tvalid), .rx_tready_o(rx_tready_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] rx;
    int          stall_idx;
    int          stall_len;
    logic        early;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_ready(input logic exp_d, input string tag);
    int n = 0;
    while (!(imem_ready_o | dmem_ready_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " grant"}, {126'b0, dmem_ready_o, imem_ready_o}, exp_d ? 128'd2 : 128'd1);
    check({tag, " busy"}, busy_o, 1);
    if (exp_d) dmem_valid = 1'b0;
    else imem_valid = 1'b0;
  endtask

  task automatic collect_tx(input logic [31:0] addr, input int stall_idx, input int stall_len,
                            input string tag);
    logic [31:0] got = '0;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!tx_tvalid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      check({tag, " rx held"}, rx_tready_o, 0);
      if (i == stall_idx) begin
        tx_tready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check({tag, " stall"}, {tx_tvalid_o, tx_tdata_o}, {1'b1, addr[8*i +: 8]});
        end
        tx_tready = 1'b1;
      end
      got[8*i +: 8] = tx_tdata_o;
      @(negedge clk);
    end
    check({tag, " tx bytes"}, got, addr);
  endtask

  task automatic send_rx(input logic [31:0] w, input int nbytes, input string tag);
    for (int i = 0; i < nbytes; i++) begin
      int n = 0;
      rx_tdata  = w[8*i +: 8];
      rx_tvalid = 1'b1;
      while (!rx_tready_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      check({tag, " rx ready"}, rx_tready_o, 1);
      @(negedge clk);
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic check_resp(input logic exp_d, input logic [31:0] w, input string tag);
    if (exp_d) exp_drdata = w;
    else exp_irdata = w;
    check({tag, " rvalid"}, {dmem_rvalid_o, imem_rvalid_o}, exp_d ? 128'd2 : 128'd1);
    check({tag, " rdata"}, {imem_rdata_o, dmem_rdata_o}, {exp_irdata, exp_drdata});
    check({tag, " err"}, err_o, 0);
    @(negedge clk);
    check({tag, " end"}, {dmem_rvalid_o, imem_rvalid_o, busy_o}, 0);
  endtask

  task automatic txn(input logic exp_d, input logic [31:0] addr, input logic [31:0] rx,
                     input int stall_idx, input int stall_len, input string tag);
    wait_ready(exp_d, tag);
    collect_tx(addr, stall_idx, stall_len, tag);
    send_rx(rx, 4, tag);
    check_resp(exp_d, rx, tag);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h00000008, 32'h0000A103, -1, 0, 1'b0};
    vecs[1] = '{1'b1, 32'h12345678, 32'hCAFEF00D, 2, 20, 1'b0};
    vecs[2] = '{1'b0, 32'h00000004, 32'h11223344, -1, 0, 1'b1};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 1'b0};
    vecs[4] = '{1'b0, 32'h80000003, 32'h00000000, 0, 3, 1'b0};
    vecs[5] = '{1'b1, 32'h00000001, 32'h5A5AA5A5, 3, 1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset outputs",
          {imem_ready_o, imem_rvalid_o, dmem_ready_o, dmem_rvalid_o, tx_tvalid_o, rx_tready_o,
           busy_o, err_o, tx_tdata_o, imem_rdata_o, dmem_rdata_o}, 0);
    reset_i = 1'b0;
    @(negedge clk);

    // Round-robin ties from reset: DMEM, then the held IMEM, then DMEM again.
    imem_valid = 1'b1; imem_addr = 32'h00000000;
    dmem_valid = 1'b1; dmem_addr = 32'h000003FC;
    txn(1'b1, 32'h000003FC, 32'h01020304, -1, 0, "tie1");
    txn(1'b0, 32'h00000000, 32'h0A0B0C0D, -1, 0, "tie2");
    imem_valid = 1'b1; imem_addr = 32'h00000100;
    dmem_valid = 1'b1; dmem_addr = 32'h00000200;
    txn(1'b1, 32'h00000200, 32'h77665544, -1, 0, "tie3");
    txn(1'b0, 32'h00000100, 32'h99887766, -1, 0, "tie4");

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].is_d) begin
        dmem_valid = 1'b1; dmem_addr = vecs[v].addr;
      end else begin
        imem_valid = 1'b1; imem_addr = vecs[v].addr;
      end
      if (vecs[v].early) begin
        rx_tdata  = vecs[v].rx[7:0];
        rx_tvalid = 1'b1;
      end
      txn(vecs[v].is_d, vecs[v].addr, vecs[v].rx, vecs[v].stall_idx, vecs[v].stall_len,
          $sformatf("vec%0d", v));
    end

    // Reset after two reply bytes, then a clean transaction.
    imem_valid = 1'b1; imem_addr = 32'h00000010;
    wait_ready(1'b0, "rst");
    collect_tx(32'h00000010, -1, 0, "rst");
    send_rx(32'hAABBCCDD, 2, "rst");
    reset_i = 1'b1;
    #1;
    exp_irdata = '0;
    exp_drdata = '0;
    check("async reset",
          {imem_ready_o, imem_rvalid_o, dmem_ready_o, dmem_rvalid_o, tx_tvalid_o, rx_tready_o,
           busy_o, err_o, tx_tdata_o, imem_rdata_o, dmem_rdata_o}, 0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    imem_valid = 1'b1; imem_addr = 32'h00000020;
    txn(1'b0, 32'h00000020, 32'h0BADF00D, -1, 0, "post rst");

`ifdef UART_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      dmem_valid = 1'b1; dmem_addr = 32'h00000044;
      wait_ready(1'b1, "tmo");
      collect_tx(32'h00000044, -1, 0, "tmo");
      send_rx(32'h33221100, 3, "tmo");
      while (!dmem_rvalid_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("tmo cycles", n, 50);
      check("tmo resp", {dmem_rvalid_o, err_o, dmem_rdata_o}, {1'b1, 1'b1, 32'hDEADBEEF});
      @(negedge clk);
      check("tmo end", {dmem_rvalid_o, err_o, busy_o}, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
